// File: rtl/pipe_arith_vr_if.sv
// Operand/result handshake bundle for pipe_arith_vr: valid/ready on the
// operand side and on the result side.
interface pipe_arith_vr_if #(
    parameter int W = 10
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] c;
    logic [W-1:0] d;
    logic         op_sel;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;

    modport master (
        output in_valid, a, b, c, d, op_sel, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, a, b, c, d, op_sel, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/pipe_arith_vr.sv
// Three-stage flow-controlled pipeline computing ((a+b)+(c-d)) op d modulo 2^W,
// with a wrapping count of consumed results.
module pipe_arith_vr #(
    parameter int W  = 10,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    pipe_arith_vr_if.slave bus,
    output logic [CW-1:0] done_cnt
);
    logic          v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
    logic [W-1:0]  x1_q, x1_d, x2_q, x2_d, d1_q, d1_d;
    logic          op1_q, op1_d, op2_q, op2_d;
    logic [W-1:0]  x3_q, x3_d, d2_q, d2_d;
    logic [W-1:0]  out_q, out_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          adv1, adv2, adv3;

    // A stage may load when empty or when its contents leave on the same edge.
    assign adv3 = ~v3_q | bus.out_ready;
    assign adv2 = ~v2_q | adv3;
    assign adv1 = ~v1_q | adv2;

    always_comb begin
        // NOTE: every next-state value defaults to hold first, so no path can infer a latch.
        v1_d  = v1_q;
        x1_d  = x1_q;
        x2_d  = x2_q;
        d1_d  = d1_q;
        op1_d = op1_q;
        v2_d  = v2_q;
        x3_d  = x3_q;
        d2_d  = d2_q;
        op2_d = op2_q;
        v3_d  = v3_q;
        out_d = out_q;
        cnt_d = cnt_q;

        if (adv1) begin
            v1_d = bus.in_valid;
            if (bus.in_valid) begin
                x1_d  = bus.a + bus.b;
                x2_d  = bus.c - bus.d;
                d1_d  = bus.d;
                op1_d = bus.op_sel;
            end
        end

        if (adv2) begin
            v2_d = v1_q;
            if (v1_q) begin
                x3_d  = x1_q + x2_q;
                d2_d  = d1_q;
                op2_d = op1_q;
            end
        end

        // The result register only changes on a real load, so it keeps its last value otherwise.
        if (adv3) begin
            v3_d = v2_q;
            if (v2_q) begin
                out_d = op2_q ? (x3_q + d2_q) : (x3_q * d2_q);
            end
        end

        if (v3_q && bus.out_ready) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // NOTE: only control state and visible outputs reset; stage data is don't-care while its valid is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            v1_q  <= 1'b0;
            v2_q  <= 1'b0;
            v3_q  <= 1'b0;
            out_q <= '0;
            cnt_q <= '0;
        end else begin
            v1_q  <= v1_d;
            v2_q  <= v2_d;
            v3_q  <= v3_d;
            out_q <= out_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        x1_q  <= x1_d;
        x2_q  <= x2_d;
        d1_q  <= d1_d;
        op1_q <= op1_d;
        x3_q  <= x3_d;
        d2_q  <= d2_d;
        op2_q <= op2_d;
    end

    assign bus.in_ready  = adv1;
    assign bus.out_valid = v3_q;
    assign bus.out_data  = out_q;
    assign done_cnt      = cnt_q;
endmodule

// File: tb/tb_pipe_arith_vr.sv
// Directed bench for pipe_arith_vr: a queue-based reference model checked every
// cycle, plus hand-computed literal expectations per scenario.
module tb_pipe_arith_vr;
    localparam int W  = 10;
    localparam int CW = 16;
    localparam longint MOD = longint'(1) << W;

    logic          clk;
    logic          rst;
    logic [CW-1:0] done_cnt;

    pipe_arith_vr_if #(.W(W)) bus ();

    pipe_arith_vr #(.W(W), .CW(CW)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .done_cnt (done_cnt)
    );

    int          n_checks;
    int          n_errs;
    int unsigned exp_q[$];
    int unsigned mcnt;
    bit          last_acc;

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    function automatic int unsigned model_f(input int av, input int bv, input int cv,
                                            input int dv, input bit op);
        longint x1, x2, x3, r;
        x1 = (longint'(av) + bv) % MOD;
        x2 = ((longint'(cv) - dv) % MOD + MOD) % MOD;
        x3 = (x1 + x2) % MOD;
        r  = op ? (x3 + dv) % MOD : (x3 * dv) % MOD;
        return int'(r);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Compares DUT outputs against the model, then applies the transfers of the coming edge.
    task automatic model_check();
        logic exp_rdy;
        last_acc = 1'b0;
        if (rst) begin
            exp_q.delete();
            mcnt = 0;
            return;
        end
        exp_rdy = !(exp_q.size() == 3 && !bus.out_ready);
        check("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
        check("done_cnt", 32'(done_cnt), mcnt % (32'd1 << CW));
        if (bus.out_valid) begin
            if (exp_q.size() == 0) begin
                check("stray_out_valid", 32'(bus.out_valid), 32'd0);
            end else begin
                check("out_data", 32'(bus.out_data), exp_q[0]);
                if (bus.out_ready) begin
                    void'(exp_q.pop_front());
                    mcnt++;
                end
            end
        end
        if (bus.in_valid && exp_rdy) begin
            exp_q.push_back(model_f(int'(bus.a), int'(bus.b), int'(bus.c), int'(bus.d), bus.op_sel));
            last_acc = 1'b1;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        model_check();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int av, input int bv, input int cv, input int dv, input bit op);
        bus.a      = av[W-1:0];
        bus.b      = bv[W-1:0];
        bus.c      = cv[W-1:0];
        bus.d      = dv[W-1:0];
        bus.op_sel = op;
    endtask

    task automatic send(input int av, input int bv, input int cv, input int dv, input bit op);
        bit got;
        got = 1'b0;
        drive(av, bv, cv, dv, op);
        bus.in_valid = 1'b1;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            got = last_acc;
        end
        bus.in_valid = 1'b0;
        check("accept", 32'(got), 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int k;
        n_checks      = 0;
        n_errs        = 0;
        mcnt          = 0;
        clk           = 1'b0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        drive(0, 0, 0, 0, 1'b0);

        // Reset state
        do_reset();
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_data", 32'(bus.out_data), 32'd0);
        check("rst_done_cnt", 32'(done_cnt), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);

        // Basic latency: result two edges after the accept edge
        send(3, 4, 10, 2, 1'b0);
        check("basic_lat0", 32'(bus.out_valid), 32'd0);
        tick();
        check("basic_lat1", 32'(bus.out_valid), 32'd0);
        tick();
        check("basic_valid", 32'(bus.out_valid), 32'd1);
        check("basic_data", 32'(bus.out_data), 32'd30);
        tick();
        check("basic_drained", 32'(bus.out_valid), 32'd0);
        check("basic_done_cnt", 32'(done_cnt), 32'd1);

        // Modular wrap on a+b and c-d
        send(512, 512, 5, 3, 1'b0);
        send(0, 0, 0, 1, 1'b0);
        tick();
        check("wrap_first", 32'(bus.out_data), 32'd6);
        tick();
        check("wrap_second_valid", 32'(bus.out_valid), 32'd1);
        check("wrap_second", 32'(bus.out_data), 32'd1023);
        tick();

        // Operation select and truncated multiply
        send(3, 4, 10, 2, 1'b1);
        send(100, 100, 100, 1000, 1'b0);
        tick();
        check("mode_add", 32'(bus.out_data), 32'd17);
        tick();
        check("mode_mul", 32'(bus.out_data), 32'd416);
        tick();
        tick();

        // Backpressure: five results 1..5 with the consumer stalled for six cycles
        do_reset();
        bus.out_ready = 1'b0;
        k = 1;
        for (int cyc = 0; cyc < 14; cyc++) begin
            if (cyc == 5) begin
                check("bp_stall_valid", 32'(bus.out_valid), 32'd1);
                check("bp_stall_data", 32'(bus.out_data), 32'd1);
                check("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
            end
            if (cyc >= 6 && cyc <= 10) begin
                check("bp_no_gap", 32'(bus.out_valid), 32'd1);
                check("bp_order", 32'(bus.out_data), 32'(cyc - 5));
            end
            bus.out_ready = (cyc >= 6);
            bus.in_valid  = (k <= 5);
            drive(k, 0, 0, 1, 1'b1);
            tick();
            if (last_acc) k++;
        end
        bus.in_valid = 1'b0;
        check("bp_accepted", 32'(k), 32'd6);
        check("bp_done_cnt", 32'(done_cnt), 32'd5);

        // Bubbles: out_valid replays the in_valid pattern two edges later
        do_reset();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.in_valid = (i < 6) && (i % 2 == 0);
            drive(i + 1, 0, 0, 1, 1'b1);
            tick();
            if (i >= 2) begin
                check("bubble_pattern", 32'(bus.out_valid), 32'((i - 2) % 2 == 0));
            end
        end
        bus.in_valid = 1'b0;
        tick();

        // Reset with three transactions in flight
        do_reset();
        bus.out_ready = 1'b0;
        send(1, 1, 1, 1, 1'b1);
        send(2, 2, 2, 1, 1'b1);
        send(3, 3, 3, 1, 1'b1);
        tick();
        check("midrst_pre_valid", 32'(bus.out_valid), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_out_data", 32'(bus.out_data), 32'd0);
        check("midrst_done_cnt", 32'(done_cnt), 32'd0);
        check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("midrst_no_stale", 32'(bus.out_valid), 32'd0);
        end
        send(3, 4, 10, 2, 1'b0);
        tick();
        tick();
        check("midrst_new_valid", 32'(bus.out_valid), 32'd1);
        check("midrst_new_data", 32'(bus.out_data), 32'd30);
        tick();
        check("midrst_new_done", 32'(done_cnt), 32'd1);
        tick();

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end
endmodule
